scm_write_arbiter: RTL and testbench
====================================

SCM_WRITE_ARBITER -- requirements
Module: scm_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of write requesters, range 2..8.
REQ-002 SHALL have parameter WADDR_WIDTH, default 5: SCM word address width.
REQ-003 SHALL have parameter WDATA_WIDTH, default 64: SCM write word width.
REQ-004 SHALL have parameter RDATA_WIDTH, default 32: SCM read width; WDATA_WIDTH/RDATA_WIDTH is a power of two.
REQ-005 SHALL have parameter N_READ, default 4: number of SCM read ports checked for hazards.
REQ-006 SHALL have ports:
- clk  in  1: single clock; the block uses one clock, rising edge.
- rst  in  1: reset, synchronous, active-high.
- req_i  in  N_REQ: per-requester write request.
- addr_i  in  N_REQ x WADDR_WIDTH: per-requester word address.
- wdata_i  in  N_REQ x WDATA_WIDTH: per-requester write data.
- gnt_o  out  N_REQ: one-hot grant, at most one bit high.
- hold_i  in  1: blocks new grants while high.
- WriteEnable  out  1: SCM write enable.
- WriteAddr  out  WADDR_WIDTH: SCM write address.
- WriteData  out  WDATA_WIDTH: SCM write data.
- rd_en_i  in  N_READ: SCM read enables.
- rd_addr_i  in  N_READ x (WADDR_WIDTH+log2(WDATA_WIDTH/RDATA_WIDTH)): SCM read addresses.
- rd_hazard_o  out  N_READ: read targets a word with a write in flight.
- busy_o  out  1: any write in flight.

Function
REQ-007 A requester SHALL hold req_i, addr_i and wdata_i stable until it sees gnt_o high; the transfer completes in the cycle where req_i and gnt_o are both high.
REQ-008 gnt_o SHALL be combinational from req_i, hold_i and the priority state; gnt_o SHALL be zero when hold_i=1 or rst=1.
REQ-009 The granted requester's address and data SHALL be registered; WriteEnable/WriteAddr/WriteData SHALL be driven in cycle N+1 for a grant in cycle N (latency 1).
REQ-010 WriteEnable SHALL be high for exactly one cycle per grant; back-to-back grants SHALL give back-to-back writes (throughput 1 write per cycle).
REQ-011 With no grant in cycle N, WriteEnable SHALL be 0 in N+1, and WriteAddr/WriteData SHALL hold their previous values.
REQ-012 In-flight tracking SHALL be a 2-stage pipe of {valid, addr}. Stage A covers the cycle WriteEnable is high (N+1). Stage B covers the latch-update cycle (N+2).
REQ-013 rd_hazard_o[p] SHALL be 1 iff rd_en_i[p]=1 and rd_addr_i[p] >> log2(WDATA_WIDTH/RDATA_WIDTH) equals the address of a valid stage A or stage B entry; it is combinational.
REQ-014 busy_o SHALL be the OR of the stage A and stage B valid bits.
REQ-015 Two requesters asking for the same address SHALL be served in arbitration order; the block SHALL perform no address merging.
REQ-016 hold_i rising in a cycle SHALL NOT cancel a write already registered; in-flight stages drain normally.

Reset
REQ-017 On rst=1 at a rising edge: WriteEnable=0, WriteAddr=0, WriteData=0, both stage valid bits=0, priority pointer=0.
REQ-018 A reset asserted mid-operation SHALL drop any registered but not yet issued write; no WriteEnable pulse occurs in the cycle after reset.
REQ-019 rd_hazard_o and busy_o SHALL read 0 in the first cycle after reset.

Configuration
REQ-020 Macro SCM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The pointer moves to (granted index+1) mod N_REQ after each grant; the search starts at the pointer.
REQ-021 Macro SCM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer state is present.

Verification
REQ-022 Single write: req_i=0001, addr_i[0]=5, wdata_i[0]=64'hA5 in cycle 0 -> gnt_o=0001 in cycle 0; WriteEnable=1, WriteAddr=5, WriteData=64'hA5 in cycle 1; busy_o=1 in cycles 1-2, 0 in cycle 3.
REQ-023 Contention: req_i=1111 held, each requester drops its req after its grant:
- with macro defined -> grants 0,1,2,3 in consecutive cycles;
- with macro undefined -> grants 0,1,2,3 in order, with requester 0 re-winning whenever it re-requests.
REQ-024 Hazard: write to addr 3 granted in cycle 0; rd_en_i[1]=1 with rd_addr_i[1]=7 (word 3, RDATA 32b) -> rd_hazard_o[1]=1 in cycles 1 and 2, 0 in cycle 3; rd_addr_i[1]=8 -> 0 throughout.
REQ-025 Hold: hold_i=1 with req_i=0010 for 3 cycles -> gnt_o=0 and WriteEnable=0 throughout; hold_i=0 -> gnt_o=0010 in the same cycle.
REQ-026 Reset mid-flight: grant in cycle 0, rst=1 in cycle 0 -> WriteEnable=0 in cycle 1, busy_o=0, all outputs at reset values.

Source files
------------

// File: rtl/scm_write_arbiter.sv
// Arbitrates N_REQ write requesters onto one SCM write port and flags reads that hit in-flight writes.
// Build option: define SCM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module scm_write_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WADDR_WIDTH = 5,
  parameter int unsigned WDATA_WIDTH = 64,
  parameter int unsigned RDATA_WIDTH = 32,
  parameter int unsigned N_READ      = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_REQ-1:0]                         req_i,
  input  logic [N_REQ-1:0][WADDR_WIDTH-1:0]        addr_i,
  input  logic [N_REQ-1:0][WDATA_WIDTH-1:0]        wdata_i,
  output logic [N_REQ-1:0]                         gnt_o,
  input  logic                                     hold_i,
  output logic                                     WriteEnable,
  output logic [WADDR_WIDTH-1:0]                   WriteAddr,
  output logic [WDATA_WIDTH-1:0]                   WriteData,
  input  logic [N_READ-1:0]                        rd_en_i,
  input  logic [N_READ-1:0][WADDR_WIDTH+$clog2(WDATA_WIDTH/RDATA_WIDTH)-1:0] rd_addr_i,
  output logic [N_READ-1:0]                        rd_hazard_o,
  output logic                                     busy_o
);

  localparam int unsigned SEL_SHIFT   = $clog2(WDATA_WIDTH / RDATA_WIDTH);
  localparam int unsigned RADDR_WIDTH = WADDR_WIDTH + SEL_SHIFT;
  localparam int unsigned IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW          = IDX_W + 1;

  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic                   grant_c;
  logic                   stage_b_valid;
  logic [WADDR_WIDTH-1:0] stage_b_addr;
  logic [WADDR_WIDTH-1:0] rd_word;

`ifdef SCM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [CW-1:0]    cand_w;
  logic [IDX_W-1:0] cand;

  // Round-robin search: first requester at or after the pointer, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_w    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_w = CW'(ptr_q) + CW'(i);
      if (cand_w >= CW'(N_REQ)) begin
        cand_w = cand_w - CW'(N_REQ);
      end
      cand = cand_w[IDX_W-1:0];
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_c) begin
      ptr_q <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_i[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Grant is suppressed while held or in reset so no transfer completes then.
  always_comb begin
    grant_c = win_found && !hold_i && !rst;
    gnt_o   = '0;
    if (grant_c) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  // Stage A is the write port register itself; stage B trails it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteEnable   <= 1'b0;
      WriteAddr     <= '0;
      WriteData     <= '0;
      stage_b_valid <= 1'b0;
      stage_b_addr  <= '0;
    end else begin
      WriteEnable <= grant_c;
      if (grant_c) begin
        WriteAddr <= addr_i[win_idx];
        WriteData <= wdata_i[win_idx];
      end
      stage_b_valid <= WriteEnable;
      stage_b_addr  <= WriteAddr;
    end
  end

  // Read addresses are in RDATA units; drop the sub-word select bits to compare words.
  always_comb begin
    rd_hazard_o = '0;
    rd_word     = '0;
    for (int unsigned p = 0; p < N_READ; p++) begin
      rd_word        = rd_addr_i[p][RADDR_WIDTH-1:SEL_SHIFT];
      rd_hazard_o[p] = rd_en_i[p] &&
                       ((WriteEnable && (rd_word == WriteAddr)) ||
                        (stage_b_valid && (rd_word == stage_b_addr)));
    end
  end

  assign busy_o = WriteEnable | stage_b_valid;

endmodule

// File: tb/tb_scm_write_arbiter.sv
// Self-checking bench for scm_write_arbiter: directed scenarios followed by randomized traffic
// checked every cycle against a cycle-indexed grant log.
module tb_scm_write_arbiter;
  localparam int N    = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int RW   = 32;
  localparam int NR   = 4;
  localparam int SH   = $clog2(DW / RW);
  localparam int RAW  = AW + SH;
  localparam int MAXC = 1024;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0][AW-1:0]   addr;
  logic [N-1:0][DW-1:0]   wdata;
  logic [N-1:0]           gnt_o;
  logic                   hold;
  logic                   WriteEnable;
  logic [AW-1:0]          WriteAddr;
  logic [DW-1:0]          WriteData;
  logic [NR-1:0]          rd_en;
  logic [NR-1:0][RAW-1:0] rd_addr;
  logic [NR-1:0]          rd_hazard_o;
  logic                   busy_o;

  int checks   = 0;
  int failures = 0;

  // Reference state: which cycle granted a write and to what word.
  int            gv [MAXC];
  int            ga [MAXC];
  int            cyc;
  int            ptr;
  int            last_win;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  scm_write_arbiter #(
    .N_REQ(N), .WADDR_WIDTH(AW), .WDATA_WIDTH(DW), .RDATA_WIDTH(RW), .N_READ(NR)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_o),
    .hold_i(hold), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_hazard_o(rd_hazard_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int model_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
`ifdef SCM_ARB_ROUND_ROBIN_EN
      j = (p + k) % N;
`else
      j = k + 0 * p;
`endif
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: check all outputs mid-cycle against the log, then record this cycle's grant.
  task automatic cycle();
    int            w;
    logic [N-1:0]  eg;
    logic [NR-1:0] ehz;
    int            word;
    @(negedge clk);
    w  = (hold || rst) ? -1 : model_win(req, ptr);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 64'(gnt_o), 64'(eg));
    chk("we", 64'(WriteEnable), 64'(gv[cyc-1]));
    chk("waddr", 64'(WriteAddr), 64'(last_addr));
    chk("wdata", WriteData, last_data);
    chk("busy", 64'(busy_o), 64'((gv[cyc-1] != 0) || (gv[cyc-2] != 0)));
    ehz = '0;
    for (int p = 0; p < NR; p++) begin
      word   = int'(rd_addr[p]) / (1 << SH);
      ehz[p] = rd_en[p] && ((gv[cyc-1] != 0 && word == ga[cyc-1]) ||
                            (gv[cyc-2] != 0 && word == ga[cyc-2]));
    end
    chk("hazard", 64'(rd_hazard_o), 64'(ehz));
    last_win = w;
    if (w >= 0) begin
      gv[cyc]   = 1;
      ga[cyc]   = int'(addr[w]);
      last_addr = addr[w];
      last_data = wdata[w];
      ptr       = (w + 1) % N;
    end
    if (rst) begin
      gv[cyc-1] = 0;
      last_addr = '0;
      last_data = '0;
      ptr       = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; req = '0; addr = '0; wdata = '0; rd_en = '0; rd_addr = '0;
    cyc = 2; ptr = 0; last_win = -1; last_addr = '0; last_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write
    req = 4'b0001; addr[0] = 5'd5; wdata[0] = 64'hA5;
    #1 chk("single_gnt", 64'(gnt_o), 64'h1);
    cycle();
    req = '0;
    chk("single_we", 64'(WriteEnable), 64'h1);
    chk("single_addr", 64'(WriteAddr), 64'd5);
    chk("single_data", WriteData, 64'hA5);
    chk("single_busy1", 64'(busy_o), 64'h1);
    cycle();
    chk("single_busy2", 64'(busy_o), 64'h1);
    chk("single_we_off", 64'(WriteEnable), 64'h0);
    cycle();
    chk("single_busy3", 64'(busy_o), 64'h0);

    // Contention with each requester dropping after its grant
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      addr[k] = AW'(10 + k); wdata[k] = 64'(100 + k);
    end
    for (int k = 0; k < N; k++) begin
      #1 chk("cont_gnt", 64'(gnt_o), 64'(1 << k));
      cycle();
      req[k] = 1'b0;
    end
    req = 4'b0110;
    cycle();
    req = 4'b0101;
`ifdef SCM_ARB_ROUND_ROBIN_EN
    #1 chk("rereq_gnt", 64'(gnt_o), 64'h4);
`else
    #1 chk("rereq_gnt", 64'(gnt_o), 64'h1);
`endif
    cycle();
    req = '0;
    repeat (2) cycle();

    // Read hazard on word 3, no hazard on word 4
    req = 4'b0001; addr[0] = 5'd3; wdata[0] = 64'h33;
    rd_en = 4'b0110; rd_addr[1] = 6'd7; rd_addr[2] = 6'd8;
    cycle();
    req = '0;
    chk("haz_c1", 64'(rd_hazard_o), 64'h2);
    cycle();
    chk("haz_c2", 64'(rd_hazard_o), 64'h2);
    cycle();
    chk("haz_c3", 64'(rd_hazard_o), 64'h0);
    rd_en = '0;

    // Hold blocks grants, release grants in the same cycle
    hold = 1'b1; req = 4'b0010; addr[1] = 5'd17;
    repeat (3) begin
      #1 chk("hold_gnt", 64'(gnt_o), 64'h0);
      cycle();
      chk("hold_we", 64'(WriteEnable), 64'h0);
    end
    hold = 1'b0;
    #1 chk("release_gnt", 64'(gnt_o), 64'h2);
    cycle();
    req = '0;
    cycle();

    // Reset with a request pending, then reset with a write in flight
    req = 4'b0001; addr[0] = 5'd9; rst = 1'b1;
    #1 chk("rst_gnt", 64'(gnt_o), 64'h0);
    cycle();
    rst = 1'b0; req = '0;
    chk("rst_we", 64'(WriteEnable), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_addr", 64'(WriteAddr), 64'h0);
    req = 4'b0001;
    cycle();
    req = '0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_drain_busy", 64'(busy_o), 64'h0);
    cycle();

    // Randomized traffic
    repeat (600) begin
      hold = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) begin
        if (req[k] && last_win == k) req[k] = 1'b0;
        if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k]   = 1'b1;
          addr[k]  = AW'($urandom);
          wdata[k] = {$urandom, $urandom};
        end
      end
      for (int p = 0; p < NR; p++) begin
        rd_en[p] = 1'($urandom);
        if ($urandom_range(0, 1) == 1)
          rd_addr[p] = RAW'(ga[cyc - 1 - int'($urandom_range(0, 1))] * (1 << SH) +
                            int'($urandom_range(0, (1 << SH) - 1)));
        else
          rd_addr[p] = RAW'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
